// File: rtl/gaussian_filter_3x3_if.sv
// Pixel stream bundle (data, valid, ready, last) between raster stages.
// A master drives data/valid/last; a slave returns ready and ignores last.
interface gaussian_filter_3x3_if #(
  parameter int PIXEL_BIT_WIDTH = 16
);
  logic [PIXEL_BIT_WIDTH-1:0] TDATA;
  logic                       TVALID;
  logic                       TREADY;
  logic                       TLAST;

  modport master (output TDATA, output TVALID, output TLAST, input TREADY);
  modport slave  (input TDATA, input TVALID, output TREADY);
endinterface

// File: rtl/gaussian_filter_3x3.sv
// Streaming 3x3 Gaussian blur [1 2 1;2 4 2;1 2 1]/16 over the valid region, 1-cycle latency.
// Backpressure: single output register; GAUSS_ROUND_EN selects round-half-up instead of truncation.
module gaussian_filter_3x3 #(
  parameter int PIXEL_BIT_WIDTH = 16,
  parameter int ROWS            = 48,
  parameter int COLS            = 48
) (
  input  logic                  clk,
  input  logic                  reset,
  gaussian_filter_3x3_if.slave  pixel_in,
  gaussian_filter_3x3_if.master pixel_out
);
  localparam int W  = PIXEL_BIT_WIDTH;
  localparam int SW = PIXEL_BIT_WIDTH + 4;
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [W-1:0]  lb0 [COLS];
  logic [W-1:0]  lb1 [COLS];
  logic [W-1:0]  t0, m0, b0, t1, m1, b1;
  logic [W-1:0]  t2, m2, b2;
  logic          out_vld;
  logic [W-1:0]  out_dat;
  logic          out_last;
  logic          in_rdy, in_acc, out_acc, emit;
  logic [SW-1:0] sum, sum_r;
  logic [W-1:0]  result;

  function automatic logic [SW-1:0] vsum(input logic [W-1:0] t, input logic [W-1:0] m,
                                         input logic [W-1:0] b);
    return SW'(t) + (SW'(m) << 1) + SW'(b);
  endfunction

  assign in_rdy  = !out_vld || pixel_out.TREADY;
  assign in_acc  = pixel_in.TVALID && in_rdy;
  assign out_acc = out_vld && pixel_out.TREADY;

  assign t2 = lb1[col];
  assign m2 = lb0[col];
  assign b2 = pixel_in.TDATA;

  assign sum = vsum(t0, m0, b0) + (vsum(t1, m1, b1) << 1) + vsum(t2, m2, b2);
`ifdef GAUSS_ROUND_EN
  assign sum_r = sum + SW'(8);
`else
  assign sum_r = sum;
`endif
  assign result = W'(sum_r >> 4);

  // Stale window taps from the previous row are harmless: c<2 never emits.
  assign emit = in_acc && (row >= RW'(2)) && (col >= CW'(2));

  always_ff @(posedge clk) begin
    if (in_acc) begin
      lb1[col] <= lb0[col];
      lb0[col] <= pixel_in.TDATA;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col      <= '0;
      row      <= '0;
      t0       <= '0;
      m0       <= '0;
      b0       <= '0;
      t1       <= '0;
      m1       <= '0;
      b1       <= '0;
      out_vld  <= 1'b0;
      out_dat  <= '0;
      out_last <= 1'b0;
    end else begin
      if (in_acc) begin
        t0 <= t1;
        m0 <= m1;
        b0 <= b1;
        t1 <= t2;
        m1 <= m2;
        b1 <= b2;
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
      if (emit) begin
        out_vld  <= 1'b1;
        out_dat  <= result;
        out_last <= (row == ROW_LAST) && (col == COL_LAST);
      end else if (out_acc) begin
        out_vld <= 1'b0;
      end
    end
  end

  assign pixel_in.TREADY  = in_rdy;
  assign pixel_out.TVALID = out_vld;
  assign pixel_out.TDATA  = out_dat;
  assign pixel_out.TLAST  = out_last;
endmodule
